// File: rtl/seven_seg_capture.sv
// Monitors a multiplexed quad seven-segment display bus and recovers the hex value
// shown on each digit once its anode/segment pattern has been stable long enough.
module seven_seg_capture #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       an3,
   input  logic       an2,
   input  logic       an1,
   input  logic       an0,
   input  logic       ca,
   input  logic       cb,
   input  logic       cc,
   input  logic       cd,
   input  logic       ce,
   input  logic       cf,
   input  logic       cg,
   input  logic       dp,
   output logic [3:0] val3,
   output logic [3:0] val2,
   output logic [3:0] val1,
   output logic [3:0] val0,
   output logic [3:0] digit_valid,
   output logic       frame_valid,
   output logic       decode_err,
   output logic [7:0] err_count
);

   localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [11:0] BLANK       = 12'hFFF;

   logic [11:0] pins;
   logic [11:0] samp;
   logic [7:0]  cnt;
   logic [3:0]  seen;
   logic [3:0]  val_q [4];

   logic [3:0] s_an;
   logic       s_dp;
   logic [6:0] s_seg;
   logic       accept;
   logic       dec_hit;
   logic [3:0] dec_code;
   logic       single;
   logic [1:0] idx;
   logic [3:0] sel;
   logic       is_blank;
   logic       good;
   logic       bad;

   assign pins  = {an3, an2, an1, an0, dp, ca, cb, cc, cd, ce, cf, cg};
   assign s_an  = samp[11:8];
   assign s_dp  = samp[7];
   assign s_seg = samp[6:0];

   // One accept per stable window: the counter passes through SETTLE_LAST only once.
   assign accept   = (pins == samp) && (cnt == SETTLE_LAST);
   assign is_blank = (s_an == 4'hF);
   assign sel      = 4'b0001 << idx;
   assign good     = accept && single && s_dp && dec_hit;
   assign bad      = accept && !is_blank && !(single && s_dp && dec_hit);

   always_comb begin
      dec_hit  = 1'b1;
      dec_code = 4'h0;
      case (s_seg)
         7'b0000001: dec_code = 4'h0;
         7'b1001111: dec_code = 4'h1;
         7'b0010010: dec_code = 4'h2;
         7'b0000110: dec_code = 4'h3;
         7'b1001100: dec_code = 4'h4;
         7'b0100100: dec_code = 4'h5;
         7'b0100000: dec_code = 4'h6;
         7'b0001111: dec_code = 4'h7;
         7'b0000000: dec_code = 4'h8;
         7'b0000100: dec_code = 4'h9;
         7'b0001000: dec_code = 4'hA;
         7'b1100000: dec_code = 4'hB;
         7'b0110001: dec_code = 4'hC;
         7'b1000010: dec_code = 4'hD;
         7'b0110000: dec_code = 4'hE;
         7'b0111000: dec_code = 4'hF;
         default:    dec_hit  = 1'b0;
      endcase
   end

   always_comb begin
      single = 1'b0;
      idx    = 2'd0;
      case (s_an)
         4'b1110: begin single = 1'b1; idx = 2'd0; end
         4'b1101: begin single = 1'b1; idx = 2'd1; end
         4'b1011: begin single = 1'b1; idx = 2'd2; end
         4'b0111: begin single = 1'b1; idx = 2'd3; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         samp        <= BLANK;
         cnt         <= 8'd0;
         seen        <= 4'd0;
         digit_valid <= 4'd0;
         frame_valid <= 1'b0;
         decode_err  <= 1'b0;
         err_count   <= 8'd0;
         for (int i = 0; i < 4; i++) val_q[i] <= 4'd0;
      end else begin
         samp        <= pins;
         frame_valid <= 1'b0;
         decode_err  <= 1'b0;
         if (pins != samp)
            cnt <= 8'd0;
         else if (cnt != SETTLE_MAX)
            cnt <= cnt + 8'd1;

         if (good) begin
            val_q[idx]       <= dec_code;
            digit_valid[idx] <= 1'b1;
            if ((seen | sel) == 4'hF) begin
               frame_valid <= 1'b1;
               seen        <= 4'd0;
            end else begin
               seen <= seen | sel;
            end
         end

         if (bad) begin
            decode_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
      end
   end

   assign val0 = val_q[0];
   assign val1 = val_q[1];
   assign val2 = val_q[2];
   assign val3 = val_q[3];

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: table of display windows plus hand sequences, with an
// independent decode model feeding an expected-output queue checked at each accept edge.
module tb_seven_seg_capture;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] val3, val2, val1, val0, digit_valid;
   logic       frame_valid, decode_err;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   seven_seg_capture #(.SETTLE_CYCLES(N)) dut (
      .clk(clk), .rst(rst),
      .an3(an[3]), .an2(an[2]), .an1(an[1]), .an0(an[0]),
      .ca(seg[6]), .cb(seg[5]), .cc(seg[4]), .cd(seg[3]), .ce(seg[2]), .cf(seg[1]), .cg(seg[0]),
      .dp(dp),
      .val3(val3), .val2(val2), .val1(val1), .val0(val0),
      .digit_valid(digit_valid), .frame_valid(frame_valid), .decode_err(decode_err),
      .err_count(err_count)
   );

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      int         hold;
      logic       exp_fv;
      logic       exp_de;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   logic [29:0] exp_q[$];
   logic [6:0]  seg_tab [16];
   vec_t        vecs[$];

   logic [3:0]  m_val [4];
   logic [3:0]  m_dv, m_seen;
   logic [7:0]  m_ec;
   logic [11:0] prev_pat;

   function automatic logic [29:0] dut_vec();
      return {val3, val2, val1, val0, digit_valid, frame_valid, decode_err, err_count};
   endfunction

   function automatic vec_t mk(logic [3:0] a, logic [6:0] s, logic d, int h, logic fv, logic de);
      vec_t v;
      v.an = a; v.seg = s; v.dp = d; v.hold = h; v.exp_fv = fv; v.exp_de = de;
      return v;
   endfunction

   task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic model_accept(input logic [3:0] a, input logic [6:0] s, input logic d);
      logic fv = 1'b0;
      logic de = 1'b0;
      int   k = 0;
      int   zeros = 0;
      int   code = -1;
      for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; k = i; end
      for (int i = 0; i < 16; i++) if (seg_tab[i] == s) code = i;
      if (zeros == 1) begin
         if (code >= 0 && d) begin
            m_val[k] = 4'(code);
            m_dv[k]  = 1'b1;
            m_seen[k] = 1'b1;
            if (m_seen == 4'hF) begin fv = 1'b1; m_seen = 4'h0; end
         end else de = 1'b1;
      end else if (zeros > 1) de = 1'b1;
      if (de && m_ec != 8'hFF) m_ec++;
      exp_q.push_back({m_val[3], m_val[2], m_val[1], m_val[0], m_dv, fv, de, m_ec});
   endtask

   task automatic reset_dut();
      an = 4'hF; seg = 7'h7F; dp = 1'b1; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
      m_dv = 4'h0; m_seen = 4'h0; m_ec = 8'h0; prev_pat = 12'hFFF;
   endtask

   // Inputs change just after an edge; the accept edge is the (N+1)-th edge that follows.
   task automatic drive_window(input logic [3:0] a, input logic [6:0] s, input logic d,
                               input int hold, output logic got_fv, output logic got_de);
      logic [11:0] pat = {a, d, s};
      logic acc = (pat != prev_pat) && (hold >= N + 1);
      logic stray = 1'b0;
      an = a; seg = s; dp = d;
      if (acc) model_accept(a, s, d);
      prev_pat = pat;
      got_fv = 1'b0; got_de = 1'b0;
      for (int c = 1; c <= hold; c++) begin
         @(posedge clk); #1;
         if (frame_valid) got_fv = 1'b1;
         if (decode_err)  got_de = 1'b1;
         if (acc && c == N + 1) check("accept", dut_vec(), exp_q.pop_front());
         else if (frame_valid || decode_err) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         failures++;
         $display("FAIL no_stray_pulse got=1 expected=0 pattern=%h", pat);
      end
   endtask

   initial begin
      logic fv, de;
      seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

      reset_dut();
      check("reset_state", dut_vec(), 30'd0);

      // All-blank anodes for a long stretch: nothing may change.
      drive_window(4'hF, 7'h7F, 1'b1, 100, fv, de);
      check("blank_hold", {dut_vec(), fv, de}, 32'd0);

      // Frame 1,2,3,4; glitch window; illegal patterns.
      vecs.push_back(mk(4'b1110, seg_tab[1], 1'b1, 8, 1'b0, 1'b0));
      vecs.push_back(mk(4'b1101, seg_tab[2], 1'b1, 8, 1'b0, 1'b0));
      vecs.push_back(mk(4'b1011, seg_tab[3], 1'b1, 8, 1'b0, 1'b0));
      vecs.push_back(mk(4'b0111, seg_tab[4], 1'b1, 8, 1'b1, 1'b0));
      vecs.push_back(mk(4'b1110, seg_tab[5], 1'b1, 3, 1'b0, 1'b0));
      vecs.push_back(mk(4'b1110, seg_tab[6], 1'b1, 8, 1'b0, 1'b0));
      vecs.push_back(mk(4'b1100, seg_tab[8], 1'b1, 8, 1'b0, 1'b1));
      vecs.push_back(mk(4'b1101, 7'h7F,      1'b1, 8, 1'b0, 1'b1));
      vecs.push_back(mk(4'b1101, seg_tab[1], 1'b0, 8, 1'b0, 1'b1));
      foreach (vecs[i]) begin
         drive_window(vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].hold, fv, de);
         check($sformatf("table_pulses_%0d", i), {28'd0, fv, de}, {28'd0, vecs[i].exp_fv, vecs[i].exp_de});
      end
      check("after_table", dut_vec(), {4'h4, 4'h3, 4'h2, 4'h6, 4'hF, 1'b0, 1'b0, 8'd3});

      // Partial frame discarded by reset.
      reset_dut();
      drive_window(4'b1110, seg_tab[1], 1'b1, 8, fv, de);
      drive_window(4'b1101, seg_tab[2], 1'b1, 8, fv, de);
      drive_window(4'b1011, seg_tab[3], 1'b1, 8, fv, de);
      reset_dut();
      drive_window(4'b0111, seg_tab[9], 1'b1, 8, fv, de);
      check("reset_mid_frame", {dut_vec(), fv, de}, {4'h9, 4'h0, 4'h0, 4'h0, 4'b1000, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});

      // Error counter saturation with alternating illegal patterns.
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) drive_window(4'b1100, seg_tab[8], 1'b1, N + 1, fv, de);
         else            drive_window(4'b0000, seg_tab[0], 1'b1, N + 1, fv, de);
      end
      check("err_saturate", {22'd0, err_count}, {22'd0, 8'hFF});

      // Hex sweep on digit 2.
      for (int i = 0; i < 16; i++) begin
         drive_window(4'b1011, seg_tab[i], 1'b1, N + 2, fv, de);
         check($sformatf("sweep_val2_%0d", i), {26'd0, val2}, {26'd0, 4'(i)});
      end

      check("queue_drained", 30'(exp_q.size()), 30'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
